// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: bus width, register map,
// STATUS bit positions and the frame assembly state encoding.
package serial_frame_receiver_pkg;

  localparam int unsigned BUS_WIDTH = 64;

  // Only address[0] is decoded.
  localparam logic DATA_ADDR   = 1'b0;
  localparam logic STATUS_ADDR = 1'b1;

  // STATUS register bit positions.
  localparam int unsigned STATUS_VALID   = 0;
  localparam int unsigned STATUS_BUSY    = 1;
  localparam int unsigned STATUS_OVERRUN = 2;
  localparam int unsigned STATUS_TIMEOUT = 3;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous single-bit input, with a
// rising-edge pulse derived from the synchronized value and its previous copy.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous input
//   sync_o  synchronized input (Stages clocks of latency)
//   rise_o  high for one cycle when sync_o goes 0 -> 1; same cycle as sync_o
module sync_edge_detect #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign sync_o = sync_q[Stages-1];
  // Combinational so a sibling instance's sync_o lines up with this pulse.
  assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/triState.sv
// Tristate bus driver cell.
//   data_i  value to drive
//   en_i    drive enable; when low the output floats
//   data_o  tristate output
module triState #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] data_i,
  input  logic             en_i,
  output tri   [Width-1:0] data_o
);

  assign data_o = en_i ? data_i : {Width{1'bz}};

endmodule

// File: rtl/serial_frame_receiver.sv
// Read-only bus peripheral that receives the CPU's bit-banged two-wire serial
// stream (ser_clk / ser_data, LSB first) and presents each completed frame in
// a DATA register alongside a STATUS register.
//   clock, reset          system clock, asynchronous active-low reset
//   ser_clk, ser_data     asynchronous serial lines
//   address               only address[0] decoded: 0 = DATA, 1 = STATUS
//   chip_select,
//   output_enable         read strobe pair; data driven only while both high
//   data                  64-bit tristate read bus
//   irq                   mirrors rx_valid
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned FRAME_BITS     = 12,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ser_clk,
  input  logic                 ser_data,
  input  logic [31:0]          address,
  input  logic                 chip_select,
  input  logic                 output_enable,
  output tri   [BUS_WIDTH-1:0] data,
  output logic                 irq
);

  localparam int unsigned BitCntW = $clog2(FRAME_BITS + 1);
  localparam int unsigned IdleW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(FRAME_BITS - 1);
  localparam logic [IdleW-1:0]   IdleMax = IdleW'(TIMEOUT_CYCLES - 1);

  state_e                  state_q;
  logic [BitCntW-1:0]      bit_cnt_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [FRAME_BITS-1:0]   shift_next;
  logic [FRAME_BITS-1:0]   rx_word_q;
  logic                    rx_valid_q;
  logic                    overrun_q;
  logic                    timeout_err_q;
  logic [IdleW-1:0]        idle_cnt_q;
  logic                    acc_q;

  logic                    clk_rise;
  logic                    clk_sync_unused;
  logic                    ser_bit;
  logic                    data_rise_unused;
  logic                    acc;
  logic                    acc_first;
  logic                    data_clear;
  logic                    status_clear;
  logic                    frame_done;
  logic                    timeout_hit;
  logic [BUS_WIDTH-1:0]    status_word;
  logic [BUS_WIDTH-1:0]    read_word;
  logic [30:0]             addr_unused;

  assign addr_unused = address[31:1];

  sync_edge_detect #(
    .Stages (SYNC_STAGES)
  ) u_clk_sync (
    .clk_i  (clock),
    .rst_ni (reset),
    .d_i    (ser_clk),
    .sync_o (clk_sync_unused),
    .rise_o (clk_rise)
  );

  sync_edge_detect #(
    .Stages (SYNC_STAGES)
  ) u_data_sync (
    .clk_i  (clock),
    .rst_ni (reset),
    .d_i    (ser_data),
    .sync_o (ser_bit),
    .rise_o (data_rise_unused)
  );

  // Side effects fire only on the first cycle of a held access.
  assign acc          = chip_select & output_enable;
  assign acc_first    = acc & ~acc_q;
  assign data_clear   = acc_first & (address[0] == DATA_ADDR);
  assign status_clear = acc_first & (address[0] == STATUS_ADDR);

  assign frame_done  = clk_rise & (((state_q == IDLE) && (FRAME_BITS == 1)) ||
                                   ((state_q == SHIFT) && (bit_cnt_q == LastBit)));
  assign timeout_hit = (state_q == SHIFT) & ~clk_rise & (idle_cnt_q == IdleMax);

  // Shift register with the current bit inserted; a new frame starts from zero.
  always_comb begin
    shift_next = (state_q == SHIFT) ? shift_q : '0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (BitCntW'(i) == bit_cnt_q) begin
        shift_next[i] = ser_bit;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_word_q     <= '0;
      rx_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      idle_cnt_q    <= '0;
      acc_q         <= 1'b0;
    end else begin
      acc_q <= acc;

      // Clears come first so that a same-cycle set below takes priority.
      if (data_clear) begin
        rx_valid_q <= 1'b0;
      end
      if (status_clear) begin
        overrun_q     <= 1'b0;
        timeout_err_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (clk_rise) begin
            idle_cnt_q <= '0;
            if (!frame_done) begin
              shift_q   <= shift_next;
              bit_cnt_q <= BitCntW'(1);
              state_q   <= SHIFT;
            end
          end else if (idle_cnt_q != IdleMax) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            idle_cnt_q <= '0;
            if (frame_done) begin
              shift_q   <= '0;
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              shift_q   <= shift_next;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (timeout_hit) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            state_q       <= IDLE;
            timeout_err_q <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
      endcase

      if (frame_done) begin
        rx_word_q  <= shift_next;
        rx_valid_q <= 1'b1;
        // A word consumed in this very cycle is not an overrun.
        if (rx_valid_q && !data_clear) begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    status_word                 = '0;
    status_word[STATUS_VALID]   = rx_valid_q;
    status_word[STATUS_BUSY]    = (state_q == SHIFT);
    status_word[STATUS_OVERRUN] = overrun_q;
    status_word[STATUS_TIMEOUT] = timeout_err_q;
    read_word = (address[0] == STATUS_ADDR) ? status_word : BUS_WIDTH'(rx_word_q);
  end

  triState #(
    .Width (BUS_WIDTH)
  ) u_bus_drv (
    .data_i (read_word),
    .en_i   (acc),
    .data_o (data)
  );

  assign irq = rx_valid_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: frames are bit-banged with
// 20-clock low/high phases and results are read back over the bus.
module tb_serial_frame_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        ser_clk;
  logic        ser_data;
  logic [31:0] address;
  logic        chip_select;
  logic        output_enable;
  wire  [63:0] data;
  logic        irq;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [63:0] rd;

  always #5 clock = ~clock;

  // Parks the bus at zero whenever the DUT should be floating, so any
  // stray drive from the DUT shows up as a nonzero value.
  assign data = (chip_select && output_enable) ? {64{1'bz}} : 64'h0;

  serial_frame_receiver #(
    .FRAME_BITS     (12),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ser_clk       (ser_clk),
    .ser_data      (ser_data),
    .address       (address),
    .chip_select   (chip_select),
    .output_enable (output_enable),
    .data          (data),
    .irq           (irq)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser_clk  = 1'b0;
    ser_data = b;
    tick(20);
    ser_clk = 1'b1;
    tick(20);
  endtask

  task automatic send_frame(input logic [11:0] w);
    for (int i = 0; i < 12; i++) begin
      send_bit(w[i]);
    end
  endtask

  // One-cycle read access followed by one idle cycle.
  task automatic bus_read(input logic a, output logic [63:0] v);
    address       = {31'b0, a};
    chip_select   = 1'b1;
    output_enable = 1'b1;
    #1;
    v = data;
    @(posedge clock);
    #1;
    chip_select   = 1'b0;
    output_enable = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [11:0] w;

    reset         = 1'b0;
    ser_clk       = 1'b0;
    ser_data      = 1'b0;
    address       = '0;
    chip_select   = 1'b0;
    output_enable = 1'b0;
    tick(3);
    check("irq_in_reset", {63'b0, irq}, 64'h0);
    reset = 1'b1;
    tick(2);
    bus_read(1'b1, rd);
    check("status_after_reset", rd, 64'h0);
    bus_read(1'b0, rd);
    check("data_after_reset", rd, 64'h0);

    // Basic frame.
    send_frame(12'hAAA);
    check("irq_after_aaa", {63'b0, irq}, 64'h1);
    bus_read(1'b1, rd);
    check("status_valid_aaa", rd, 64'h1);
    bus_read(1'b0, rd);
    check("data_aaa", rd, 64'h0000_0000_0000_0AAA);
    bus_read(1'b1, rd);
    check("status_after_data_read", rd, 64'h0);
    check("irq_after_read", {63'b0, irq}, 64'h0);

    // Overrun.
    send_frame(12'h123);
    send_frame(12'h456);
    bus_read(1'b1, rd);
    check("status_overrun", rd, 64'h5);
    bus_read(1'b1, rd);
    check("status_overrun_cleared", rd, 64'h1);
    bus_read(1'b0, rd);
    check("data_456", rd, 64'h456);
    bus_read(1'b1, rd);
    check("status_clean_after_overrun", rd, 64'h0);

    // Timeout after a partial frame.
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
    end
    bus_read(1'b1, rd);
    check("status_busy_partial", rd, 64'h2);
    tick(1024);
    bus_read(1'b1, rd);
    check("status_timeout", rd, 64'h8);
    bus_read(1'b1, rd);
    check("status_timeout_cleared", rd, 64'h0);
    send_frame(12'hF0F);
    bus_read(1'b1, rd);
    check("status_after_timeout_frame", rd, 64'h1);
    bus_read(1'b0, rd);
    check("data_f0f", rd, 64'hF0F);

    // Reset mid-frame.
    w = 12'h3C5;
    for (int i = 0; i < 7; i++) begin
      send_bit(w[i]);
    end
    reset   = 1'b0;
    ser_clk = 1'b0;
    tick(3);
    check("irq_mid_reset", {63'b0, irq}, 64'h0);
    reset = 1'b1;
    tick(3);
    bus_read(1'b1, rd);
    check("status_after_mid_reset", rd, 64'h0);
    send_frame(12'h3C5);
    bus_read(1'b1, rd);
    check("status_3c5", rd, 64'h1);
    bus_read(1'b0, rd);
    check("data_3c5", rd, 64'h3C5);

    // Final rise lands on the first cycle of a held DATA read.
    send_frame(12'h5A5);
    w = 12'h8C3;
    for (int i = 0; i < 11; i++) begin
      send_bit(w[i]);
    end
    ser_clk  = 1'b0;
    ser_data = w[11];
    tick(20);
    ser_clk = 1'b1;
    tick(2);
    address       = '0;
    chip_select   = 1'b1;
    output_enable = 1'b1;
    #1;
    check("data_old_during_coincide", data, 64'h5A5);
    tick(5);
    check("data_new_during_hold", data, 64'h8C3);
    check("irq_held_read", {63'b0, irq}, 64'h1);
    chip_select   = 1'b0;
    output_enable = 1'b0;
    tick(1);
    bus_read(1'b1, rd);
    check("status_after_coincide", rd, 64'h1);
    bus_read(1'b0, rd);
    check("data_8c3", rd, 64'h8C3);
    bus_read(1'b1, rd);
    check("status_after_8c3_read", rd, 64'h0);

    // Bus floats unless both strobes are high.
    chip_select   = 1'b0;
    output_enable = 1'b1;
    #1;
    check("hiz_cs_low", data, 64'h0);
    chip_select   = 1'b1;
    output_enable = 1'b0;
    #1;
    check("hiz_oe_low", data, 64'h0);
    chip_select = 1'b0;
    tick(2);

    // Data toggling while the serial clock is steady captures nothing.
    w = 12'h9E4;
    for (int i = 0; i < 3; i++) begin
      send_bit(w[i]);
    end
    repeat (6) begin
      ser_data = ~ser_data;
      tick(3);
    end
    ser_clk = 1'b0;
    repeat (6) begin
      ser_data = ~ser_data;
      tick(3);
    end
    bus_read(1'b1, rd);
    check("status_busy_during_toggle", rd, 64'h2);
    for (int i = 3; i < 12; i++) begin
      send_bit(w[i]);
    end
    bus_read(1'b1, rd);
    check("status_9e4", rd, 64'h1);
    bus_read(1'b0, rd);
    check("data_9e4", rd, 64'h9E4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
